// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon-MM arbiter in front of a single SDRAM controller slave port.
// Round-robin grant with bounded hold; read returns steered by an in-order master-id tag FIFO.
module sdram_port_arbiter #(
  parameter int ADDR_W      = 25,
  parameter int DATA_W      = 16,
  parameter int BE_W        = 2,
  parameter int MAX_PENDING = 8,
  parameter int HOLD_MAX    = 4
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset,

  input  logic [ADDR_W-1:0]              m0_address,
  input  logic                           m0_read,
  input  logic                           m0_write,
  input  logic [DATA_W-1:0]              m0_writedata,
  input  logic [BE_W-1:0]                m0_byteenable,
  output logic                           m0_waitrequest,
  output logic [DATA_W-1:0]              m0_readdata,
  output logic                           m0_readdatavalid,

  input  logic [ADDR_W-1:0]              m1_address,
  input  logic                           m1_read,
  input  logic                           m1_write,
  input  logic [DATA_W-1:0]              m1_writedata,
  input  logic [BE_W-1:0]                m1_byteenable,
  output logic                           m1_waitrequest,
  output logic [DATA_W-1:0]              m1_readdata,
  output logic                           m1_readdatavalid,

  output logic [ADDR_W-1:0]              sdram_address,
  output logic                           sdram_read,
  output logic                           sdram_write,
  output logic [DATA_W-1:0]              sdram_writedata,
  output logic [BE_W-1:0]                sdram_byteenable,
  input  logic                           sdram_waitrequest,
  input  logic [DATA_W-1:0]              sdram_readdata,
  input  logic                           sdram_readdatavalid,

  output logic [$clog2(MAX_PENDING):0]   pending_reads,
  output logic                           err_unexpected_rdv
);

  localparam int PTR_W  = $clog2(MAX_PENDING);
  localparam int CNT_W  = PTR_W + 1;
  localparam int HOLD_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t             state;
  state_t             state_next;
  logic               last_served;
  logic [HOLD_W-1:0]  hold_cnt;

  logic               tag_mem [MAX_PENDING];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   tag_cnt;
  logic               err_q;

  logic               req0;
  logic               req1;
  logic               fifo_full;
  logic               fifo_empty;
  logic               accept;
  logic               push;
  logic               pop;
  logic               tag_head;

  assign req0       = m0_read | m0_write;
  assign req1       = m1_read | m1_write;
  assign fifo_full  = (tag_cnt == CNT_W'(MAX_PENDING));
  assign fifo_empty = (tag_cnt == '0);
  assign push       = accept & sdram_read;
  assign pop        = sdram_readdatavalid & ~fifo_empty;
  assign tag_head   = tag_mem[rd_ptr];

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Read+write together is forwarded as a read; a full tag FIFO masks the read and stalls the master.
  always_comb begin
    state_next       = state;
    sdram_address    = '0;
    sdram_writedata  = '0;
    sdram_byteenable = '0;
    sdram_read       = 1'b0;
    sdram_write      = 1'b0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    accept           = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 && (!req1 || last_served)) begin
          state_next = GRANT0;
        end else if (req1) begin
          state_next = GRANT1;
        end
      end
      GRANT0: begin
        sdram_address    = m0_address;
        sdram_writedata  = m0_writedata;
        sdram_byteenable = m0_byteenable;
        sdram_read       = m0_read & ~fifo_full;
        sdram_write      = m0_write & ~m0_read;
        m0_waitrequest   = sdram_waitrequest | (m0_read & fifo_full);
        accept           = (sdram_read | sdram_write) & ~sdram_waitrequest;
        if (!req0 || (accept && (hold_cnt == HOLD_LAST) && req1)) begin
          state_next = req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        sdram_address    = m1_address;
        sdram_writedata  = m1_writedata;
        sdram_byteenable = m1_byteenable;
        sdram_read       = m1_read & ~fifo_full;
        sdram_write      = m1_write & ~m1_read;
        m1_waitrequest   = sdram_waitrequest | (m1_read & fifo_full);
        accept           = (sdram_read | sdram_write) & ~sdram_waitrequest;
        if (!req1 || (accept && (hold_cnt == HOLD_LAST) && req0)) begin
          state_next = req0 ? GRANT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // hold_cnt saturates so an uncontested burst cannot wrap and extend the next contested hold.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hold_cnt    <= '0;
      last_served <= 1'b1;
    end else begin
      if (state_next != state) begin
        hold_cnt <= '0;
      end else if (accept && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (accept) begin
        last_served <= (state == GRANT1);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
      if (sdram_readdatavalid && fifo_empty) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= (state == GRANT1);
    end
  end

  assign m0_readdata        = sdram_readdata;
  assign m1_readdata        = sdram_readdata;
  assign m0_readdatavalid   = pop & ~tag_head;
  assign m1_readdatavalid   = pop & tag_head;
  assign pending_reads      = tag_cnt;
  assign err_unexpected_rdv = err_q;

endmodule
